// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the fetch PC generator.
package pc_gen_pkg;

  // Value of stall_i[0] that holds the fetch stage.
  localparam logic STOP = 1'b1;

  // Default boot/reset fetch address.
  localparam logic [31:0] REBOOT_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_gen_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: increment when enabled unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: boot/run/halt FSM with redirect, stall and fetch count.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          INC       = 4,
  parameter logic [ADDR_W-1:0]    RESET_VEC = ADDR_W'(REBOOT_ADDR),
  parameter int unsigned          STALL_W   = 6,
  parameter int unsigned          CNT_W     = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_int_i,
  input  logic [ADDR_W-1:0]  int_pc_i,
  input  logic               flush_jump_i,
  input  logic [ADDR_W-1:0]  jump_pc_i,
  input  logic               halt_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               ce_o,
  output logic               misalign_o,
  output logic [CNT_W-1:0]   fetch_cnt_o
);

  // Clears the sub-INC offset bits of a redirect target.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INC - 1));

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;
  logic              cnt_en;

  // Only stall_i[0] steers fetch; the upper stage bits are deliberately unused.
  logic stall_unused;
  assign stall_unused = ^stall_i;

  // Next state, next PC, misalign flag and counter enable.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        // Redirects beat halt; halt is re-evaluated on the following edge.
        if (flush_int_i) begin
          pc_d       = int_pc_i & ALIGN_MASK;
          misalign_d = |(int_pc_i & ~ALIGN_MASK);
          cnt_en     = 1'b1;
        end else if (flush_jump_i) begin
          pc_d       = jump_pc_i & ALIGN_MASK;
          misalign_d = |(jump_pc_i & ~ALIGN_MASK);
          cnt_en     = 1'b1;
        end else if (halt_i) begin
          state_d = ST_HALT;
        end else if (stall_i[0] != STOP) begin
          pc_d   = pc_q + ADDR_W'(INC);
          cnt_en = 1'b1;
        end
      end
      ST_HALT: begin
        if (flush_int_i) begin
          pc_d       = int_pc_i & ALIGN_MASK;
          misalign_d = |(int_pc_i & ~ALIGN_MASK);
          state_d    = ST_RUN;
        end else if (!halt_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // State, PC and misalign registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_fetch_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (cnt_en),
    .count_o (fetch_cnt_o)
  );

  assign pc_o       = pc_q;
  assign ce_o       = (state_q == ST_RUN);
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with default parameters.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush_int;
  logic [31:0] int_pc;
  logic        flush_jump;
  logic [31:0] jump_pc;
  logic        halt;
  logic [31:0] pc;
  logic        ce;
  logic        misalign;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .flush_int_i  (flush_int),
    .int_pc_i     (int_pc),
    .flush_jump_i (flush_jump),
    .jump_pc_i    (jump_pc),
    .halt_i       (halt),
    .pc_o         (pc),
    .ce_o         (ce),
    .misalign_o   (misalign),
    .fetch_cnt_o  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = '0; flush_int = 1'b0; int_pc = '0;
    flush_jump = 1'b0; jump_pc = '0; halt = 1'b0;
    tick(); tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b exp 0", ce); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", misalign); end
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", fetch_cnt); end
  endtask

  task automatic test_boot_run();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h0, 32'h4, 32'h8};
    logic        exp_ce [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int          exp_cnt[4] = '{0, 0, 1, 2};
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL boot_pc[%0d] got %h exp %h", i, pc, exp_pc[i]); end
      checks++; if (ce !== exp_ce[i]) begin errors++; $display("FAIL boot_ce[%0d] got %b exp %b", i, ce, exp_ce[i]); end
      checks++; if (fetch_cnt !== 32'(exp_cnt[i])) begin errors++; $display("FAIL boot_cnt[%0d] got %0d exp %0d", i, fetch_cnt, exp_cnt[i]); end
    end
  endtask

  task automatic test_flush_priority();
    flush_jump = 1'b1; jump_pc = 32'h100;
    tick();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jump_pc got %h exp 100", pc); end
    checks++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL jump_cnt got %0d exp 3", fetch_cnt); end
    flush_int = 1'b1; int_pc = 32'h80; jump_pc = 32'h200; stall = 6'b000001;
    tick();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL prio_pc got %h exp 80", pc); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL prio_mis got %b exp 0", misalign); end
    flush_int = 1'b0; flush_jump = 1'b0;
    tick();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL stall_pc got %h exp 80", pc); end
    checks++; if (fetch_cnt !== 32'd4) begin errors++; $display("FAIL stall_cnt got %0d exp 4", fetch_cnt); end
    stall = 6'b111110;
    tick();
    checks++; if (pc !== 32'h84) begin errors++; $display("FAIL upper_stall_pc got %h exp 84", pc); end
    stall = '0;
  endtask

  task automatic test_misalign();
    flush_jump = 1'b1; jump_pc = 32'h1006;
    tick();
    checks++; if (pc !== 32'h1004) begin errors++; $display("FAIL mis_pc got %h exp 1004", pc); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b exp 1", misalign); end
    flush_jump = 1'b0;
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", misalign); end
    checks++; if (pc !== 32'h1008) begin errors++; $display("FAIL mis_next_pc got %h exp 1008", pc); end
    checks++; if (fetch_cnt !== 32'd7) begin errors++; $display("FAIL mis_cnt got %0d exp 7", fetch_cnt); end
  endtask

  task automatic test_wrap();
    flush_jump = 1'b1; jump_pc = 32'hFFFF_FFFC;
    tick();
    flush_jump = 1'b0;
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got %h exp fffffffc", pc); end
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", pc); end
    checks++; if (fetch_cnt !== 32'd9) begin errors++; $display("FAIL wrap_cnt got %0d exp 9", fetch_cnt); end
  endtask

  task automatic test_halt();
    flush_jump = 1'b1; jump_pc = 32'h40;
    tick();
    flush_jump = 1'b0; halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin flush_jump = 1'b1; jump_pc = 32'h900; end
      else flush_jump = 1'b0;
      tick();
      checks++; if (ce !== 1'b0) begin errors++; $display("FAIL halt_ce[%0d] got %b exp 0", i, ce); end
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL halt_pc[%0d] got %h exp 40", i, pc); end
    end
    flush_jump = 1'b0; halt = 1'b0;
    tick();
    checks++; if (pc !== 32'h40 || ce !== 1'b1) begin errors++; $display("FAIL halt_exit got pc %h ce %b exp pc 40 ce 1", pc, ce); end
    tick();
    checks++; if (pc !== 32'h44) begin errors++; $display("FAIL halt_resume got %h exp 44", pc); end
    checks++; if (fetch_cnt !== 32'd11) begin errors++; $display("FAIL halt_cnt got %0d exp 11", fetch_cnt); end
  endtask

  task automatic test_back_to_back();
    halt = 1'b1; flush_jump = 1'b1; jump_pc = 32'h300;
    tick();
    checks++; if (pc !== 32'h300 || ce !== 1'b1) begin errors++; $display("FAIL halt_flush got pc %h ce %b exp pc 300 ce 1", pc, ce); end
    flush_jump = 1'b0;
    tick();
    checks++; if (pc !== 32'h300 || ce !== 1'b0) begin errors++; $display("FAIL halt_after got pc %h ce %b exp pc 300 ce 0", pc, ce); end
    flush_int = 1'b1; int_pc = 32'h502;
    tick();
    checks++; if (pc !== 32'h500 || ce !== 1'b1) begin errors++; $display("FAIL halt_int got pc %h ce %b exp pc 500 ce 1", pc, ce); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL halt_int_mis got %b exp 1", misalign); end
    flush_int = 1'b0; halt = 1'b0;
    tick();
    checks++; if (pc !== 32'h504) begin errors++; $display("FAIL post_int_pc got %h exp 504", pc); end
    checks++; if (fetch_cnt !== 32'd13) begin errors++; $display("FAIL post_int_cnt got %0d exp 13", fetch_cnt); end
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    halt = 1'b1;
    tick();
    checks++; if (fetch_cnt !== 32'd5 || ce !== 1'b0 || pc !== 32'h14) begin errors++; $display("FAIL pre_rst got cnt %0d ce %b pc %h exp cnt 5 ce 0 pc 14", fetch_cnt, ce, pc); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL arst_pc got %h exp 0", pc); end
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", fetch_cnt); end
    checks++; if (ce !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL arst_ctl got ce %b mis %b exp 0 0", ce, misalign); end
    flush_int = 1'b1; int_pc = 32'h703; halt = 1'b0;
    tick();
    checks++; if (pc !== 32'h0 || ce !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL rst_ignore got pc %h ce %b mis %b exp 0 0 0", pc, ce, misalign); end
    flush_int = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if (pc !== 32'h0 || ce !== 1'b1 || fetch_cnt !== 32'd0) begin errors++; $display("FAIL rerun got pc %h ce %b cnt %0d exp 0 1 0", pc, ce, fetch_cnt); end
  endtask

  initial begin
    test_reset();
    test_boot_run();
    test_flush_priority();
    test_misalign();
    test_wrap();
    test_halt();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
